// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares the single-port 1 KB screen RAM and 1 KB character RAM between the
// Z80 bus and the video fetch engine, using the Jupiter ACE contention model.
//   0x2000 / 0x2800 : screen / char RAM, no-wait window.  The CPU always wins.
//                     A colliding video fetch returns 8'hFF ("snow").
//   0x2400 / 0x2C00 : screen / char RAM, wait window.  The CPU is held in
//                     WAIT until the display is inactive and the same RAM has
//                     no video fetch that cycle.
//
// Ports
//   clk_65, reset                 clock, synchronous active-high reset
//   cpu_addr, mreq_n, rd_n, wr_n  Z80 address bus and active-low strobes
//   cpu_dout / cpu_din            CPU write data / read data to the CPU
//   cpu_din_oe                    cpu_din is valid for the data bus mux
//   wait_n                        Z80 WAIT, active-low, combinational
//   vid_active                    beam inside the active display area
//   vid_scr_req/addr, vid_chr_req/addr   video fetch requests (1-cycle pulses)
//   vid_scr_data/valid, vid_chr_data/valid video fetch results, latency 1
//   sram_* / cram_*               synchronous RAM ports, 1-cycle read latency
// ---------------------------------------------------------------------------
module vram_arbiter (
   input  logic       clk_65,
   input  logic       reset,
   input  logic [15:0] cpu_addr,
   input  logic       mreq_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic [7:0] cpu_dout,
   output logic [7:0] cpu_din,
   output logic       cpu_din_oe,
   output logic       wait_n,
   input  logic       vid_active,
   input  logic       vid_scr_req,
   input  logic [9:0] vid_scr_addr,
   input  logic       vid_chr_req,
   input  logic [9:0] vid_chr_addr,
   output logic [7:0] vid_scr_data,
   output logic       vid_scr_valid,
   output logic [7:0] vid_chr_data,
   output logic       vid_chr_valid,
   output logic [9:0] sram_addr,
   output logic       sram_we,
   output logic [7:0] sram_wdata,
   input  logic [7:0] sram_rdata,
   output logic [9:0] cram_addr,
   output logic       cram_we,
   output logic [7:0] cram_wdata,
   input  logic [7:0] cram_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      DONE
   } cpu_state_t;

   cpu_state_t state;
   cpu_state_t state_next;

   logic       cpu_hit;
   logic       cap_chr;
   logic       cap_wait;
   logic       cap_wr;
   logic [9:0] cap_addr;
   logic [7:0] cap_data;

   logic       same_req_pend;
   logic       same_req_live;
   logic       grant;
   logic       scr_grant;
   logic       chr_grant;

   logic       rd_fresh;
   logic       rd_fresh_chr;
   logic [7:0] din_q;

   logic       scr_valid_q;
   logic       chr_valid_q;
   logic       scr_noise_q;
   logic       chr_noise_q;

   // A CPU bus cycle targets the VRAM block when it is a memory read or
   // write anywhere in 0x2000-0x2FFF.
   assign cpu_hit = !mreq_n && (!rd_n || !wr_n) && (cpu_addr[15:12] == 4'h2);

   // Grant decision for the captured access.  The no-wait window is always
   // granted; the wait window needs a blanked beam and a quiet RAM port.
   // same_req_live is the equivalent video check for the access that is only
   // now being decoded in IDLE, used so WAIT can drop in the very first cycle.
   always_comb begin
      same_req_pend = cap_chr ? vid_chr_req : vid_scr_req;
      same_req_live = cpu_addr[11] ? vid_chr_req : vid_scr_req;
      grant     = (state == PEND) && (!cap_wait || (!vid_active && !same_req_pend));
      scr_grant = grant && !cap_chr;
      chr_grant = grant && cap_chr;
   end

   // WAIT is combinational so the Z80 sees it in T2.  It covers both the
   // decode cycle in IDLE and every PEND cycle until the grant.
   always_comb begin
      wait_n = 1'b1;
      if (!reset) begin
         if ((state == PEND) && cap_wait && (vid_active || same_req_pend)) begin
            wait_n = 1'b0;
         end else if ((state == IDLE) && cpu_hit && cpu_addr[10] &&
                      (vid_active || same_req_live)) begin
            wait_n = 1'b0;
         end
      end
   end

   // Next-state logic.  DONE lingers until the CPU releases MREQ so a long
   // bus cycle still produces only one RAM access.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (cpu_hit) state_next = PEND;
         PEND:    if (grant) state_next = DONE;
         DONE:    if (mreq_n) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset abandons any pending access.
   always_ff @(posedge clk_65) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Capture the target RAM, window, direction, address and data once, as
   // the access is accepted, so later bus wiggles cannot change it.
   always_ff @(posedge clk_65) begin
      if (reset) begin
         cap_chr  <= 1'b0;
         cap_wait <= 1'b0;
         cap_wr   <= 1'b0;
         cap_addr <= '0;
         cap_data <= '0;
      end else if ((state == IDLE) && cpu_hit) begin
         cap_chr  <= cpu_addr[11];
         cap_wait <= cpu_addr[10];
         cap_wr   <= !wr_n;
         cap_addr <= cpu_addr[9:0];
         cap_data <= cpu_dout;
      end
   end

   // RAM port muxes.  A granted CPU access owns its RAM for exactly one
   // cycle; otherwise the video address sits on the port as a read.  Both
   // ports are parked at address 0 with no write while reset is held, which
   // also kills a write that would otherwise be granted in the reset cycle.
   always_comb begin
      sram_addr  = '0;
      sram_we    = 1'b0;
      sram_wdata = '0;
      cram_addr  = '0;
      cram_we    = 1'b0;
      cram_wdata = '0;
      if (!reset) begin
         if (scr_grant) begin
            sram_addr  = cap_addr;
            sram_we    = cap_wr;
            sram_wdata = cap_wr ? cap_data : 8'h00;
         end else begin
            sram_addr = vid_scr_addr;
         end
         if (chr_grant) begin
            cram_addr  = cap_addr;
            cram_we    = cap_wr;
            cram_wdata = cap_wr ? cap_data : 8'h00;
         end else begin
            cram_addr = vid_chr_addr;
         end
      end
   end

   // CPU read return path.  The RAM output is valid in the cycle after the
   // grant (the first DONE cycle) and is passed straight through then, and
   // held in din_q afterwards because the port goes back to video fetches.
   always_ff @(posedge clk_65) begin
      if (reset) begin
         rd_fresh     <= 1'b0;
         rd_fresh_chr <= 1'b0;
         din_q        <= '0;
      end else begin
         rd_fresh     <= grant && !cap_wr;
         rd_fresh_chr <= cap_chr;
         if (rd_fresh) begin
            din_q <= cpu_din;
         end
      end
   end

   assign cpu_din    = rd_fresh ? (rd_fresh_chr ? cram_rdata : sram_rdata) : din_q;
   assign cpu_din_oe = !reset && (state == DONE) && !cap_wr && !rd_n;

   // Video fetch results always come back one cycle after the request.  If
   // the CPU held that RAM in the request cycle the RAM output belongs to the
   // CPU, so the video side is handed 8'hFF instead.
   always_ff @(posedge clk_65) begin
      if (reset) begin
         scr_valid_q <= 1'b0;
         chr_valid_q <= 1'b0;
         scr_noise_q <= 1'b0;
         chr_noise_q <= 1'b0;
      end else begin
         scr_valid_q <= vid_scr_req;
         chr_valid_q <= vid_chr_req;
         scr_noise_q <= vid_scr_req && scr_grant;
         chr_noise_q <= vid_chr_req && chr_grant;
      end
   end

   assign vid_scr_valid = scr_valid_q;
   assign vid_chr_valid = chr_valid_q;
   assign vid_scr_data  = !scr_valid_q ? 8'h00 : (scr_noise_q ? 8'hFF : sram_rdata);
   assign vid_chr_data  = !chr_valid_q ? 8'h00 : (chr_noise_q ? 8'hFF : cram_rdata);

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed bench for vram_arbiter.  The two RAMs are modelled here as
// synchronous 1-cycle-latency memories.  Expected read data is queued when a
// fetch or CPU read is launched and popped when the result is due.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

   logic       clk_65;
   logic       reset;
   logic [15:0] cpu_addr;
   logic       mreq_n;
   logic       rd_n;
   logic       wr_n;
   logic [7:0] cpu_dout;
   logic [7:0] cpu_din;
   logic       cpu_din_oe;
   logic       wait_n;
   logic       vid_active;
   logic       vid_scr_req;
   logic [9:0] vid_scr_addr;
   logic       vid_chr_req;
   logic [9:0] vid_chr_addr;
   logic [7:0] vid_scr_data;
   logic       vid_scr_valid;
   logic [7:0] vid_chr_data;
   logic       vid_chr_valid;
   logic [9:0] sram_addr;
   logic       sram_we;
   logic [7:0] sram_wdata;
   logic [7:0] sram_rdata;
   logic [9:0] cram_addr;
   logic       cram_we;
   logic [7:0] cram_wdata;
   logic [7:0] cram_rdata;

   logic [7:0] smem [1024];
   logic [7:0] cmem [1024];
   int         s_writes;
   int         c_writes;

   int         checks;
   int         failures;

   logic [7:0] scr_q [$];
   logic [7:0] chr_q [$];
   logic [7:0] cpu_q [$];

   vram_arbiter dut (
      .clk_65        (clk_65),
      .reset         (reset),
      .cpu_addr      (cpu_addr),
      .mreq_n        (mreq_n),
      .rd_n          (rd_n),
      .wr_n          (wr_n),
      .cpu_dout      (cpu_dout),
      .cpu_din       (cpu_din),
      .cpu_din_oe    (cpu_din_oe),
      .wait_n        (wait_n),
      .vid_active    (vid_active),
      .vid_scr_req   (vid_scr_req),
      .vid_scr_addr  (vid_scr_addr),
      .vid_chr_req   (vid_chr_req),
      .vid_chr_addr  (vid_chr_addr),
      .vid_scr_data  (vid_scr_data),
      .vid_scr_valid (vid_scr_valid),
      .vid_chr_data  (vid_chr_data),
      .vid_chr_valid (vid_chr_valid),
      .sram_addr     (sram_addr),
      .sram_we       (sram_we),
      .sram_wdata    (sram_wdata),
      .sram_rdata    (sram_rdata),
      .cram_addr     (cram_addr),
      .cram_we       (cram_we),
      .cram_wdata    (cram_wdata),
      .cram_rdata    (cram_rdata)
   );

   // Free-running system clock.
   initial begin
      clk_65 = 1'b0;
      forever #5 clk_65 = ~clk_65;
   end

   // Synchronous RAM models with write counters, so stray or repeated
   // writes are visible.
   always @(posedge clk_65) begin
      if (sram_we) begin
         smem[sram_addr] <= sram_wdata;
         s_writes        <= s_writes + 1;
      end
      sram_rdata <= smem[sram_addr];
      if (cram_we) begin
         cmem[cram_addr] <= cram_wdata;
         c_writes        <= c_writes + 1;
      end
      cram_rdata <= cmem[cram_addr];
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one cycle of inputs just after the rising edge, then return at
   // the falling edge so the caller samples settled outputs.
   task automatic applyStimulus(input logic rs, input logic mq, input logic rd,
                                input logic wr, input logic [15:0] a,
                                input logic [7:0] d, input logic va,
                                input logic sr, input logic [9:0] sa,
                                input logic cr, input logic [9:0] ca);
      @(posedge clk_65);
      #1;
      reset        = rs;
      mreq_n       = mq;
      rd_n         = rd;
      wr_n         = wr;
      cpu_addr     = a;
      cpu_dout     = d;
      vid_active   = va;
      vid_scr_req  = sr;
      vid_scr_addr = sa;
      vid_chr_req  = cr;
      vid_chr_addr = ca;
      @(negedge clk_65);
   endtask

   // One comparison: count it, and report it if it does not match.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Directed sequence.
   initial begin
      int s_base;
      int c_base;

      checks   = 0;
      failures = 0;
      s_writes = 0;
      c_writes = 0;
      sram_rdata = 8'h00;
      cram_rdata = 8'h00;
      for (int i = 0; i < 1024; i++) begin
         smem[i] = 8'h00;
         cmem[i] = 8'h00;
      end
      smem[0]      = 8'hC3;
      smem[3]      = 8'h5A;
      smem[5]      = 8'hA7;
      smem[9]      = 8'h33;
      smem[10'h10] = 8'hEE;
      cmem[10'h1F0] = 8'h81;

      reset = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      cpu_addr = '0; cpu_dout = '0; vid_active = 1'b0;
      vid_scr_req = 1'b0; vid_scr_addr = '0; vid_chr_req = 1'b0; vid_chr_addr = '0;

      $display("[TB] reset");
      applyStimulus(1, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      applyStimulus(1, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("rst_wait_n",    16'(wait_n),        16'h1);
      checkOutput("rst_din_oe",    16'(cpu_din_oe),    16'h0);
      checkOutput("rst_cpu_din",   16'(cpu_din),       16'h0);
      checkOutput("rst_scr_valid", 16'(vid_scr_valid), 16'h0);
      checkOutput("rst_chr_valid", 16'(vid_chr_valid), 16'h0);
      checkOutput("rst_scr_data",  16'(vid_scr_data),  16'h0);
      checkOutput("rst_chr_data",  16'(vid_chr_data),  16'h0);
      checkOutput("rst_sram_we",   16'(sram_we),       16'h0);
      checkOutput("rst_cram_we",   16'(cram_we),       16'h0);
      checkOutput("rst_sram_addr", 16'(sram_addr),     16'h0);
      checkOutput("rst_cram_addr", 16'(cram_addr),     16'h0);
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);

      $display("[TB] plain screen fetch");
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 1, 10'h009, 0, 10'h0);
      scr_q.push_back(smem[9]);
      checkOutput("fetch_sram_addr", 16'(sram_addr), 16'h009);
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("fetch_scr_valid", 16'(vid_scr_valid), 16'h1);
      checkOutput("fetch_scr_data",  16'(vid_scr_data),  16'(scr_q.pop_front()));
      checkOutput("fetch_chr_valid", 16'(vid_chr_valid), 16'h0);

      $display("[TB] uncontended read and hold");
      applyStimulus(0, 0, 0, 1, 16'h2405, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("rd_wait_n_n", 16'(wait_n), 16'h1);
      applyStimulus(0, 0, 0, 1, 16'h2405, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      cpu_q.push_back(smem[5]);
      checkOutput("rd_wait_n_n1", 16'(wait_n),    16'h1);
      checkOutput("rd_sram_addr", 16'(sram_addr), 16'h005);
      checkOutput("rd_sram_we",   16'(sram_we),   16'h0);
      applyStimulus(0, 0, 0, 1, 16'h2405, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("rd_din_oe", 16'(cpu_din_oe), 16'h1);
      checkOutput("rd_cpu_din", 16'(cpu_din),   16'(cpu_q.pop_front()));
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 0, 1, 16'h2405, 8'h00, 0, 0, 10'h0, 0, 10'h0);
         checkOutput("hold_din_oe",   16'(cpu_din_oe), 16'h1);
         checkOutput("hold_cpu_din",  16'(cpu_din),    16'h00A7);
         checkOutput("hold_sram_addr", 16'(sram_addr), 16'h000);
      end
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("rel_din_oe",  16'(cpu_din_oe), 16'h0);
      checkOutput("rel_cpu_din", 16'(cpu_din),    16'h00A7);
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);

      $display("[TB] contended write");
      c_base = c_writes;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(0, 0, 1, 0, 16'h2C10, 8'h3C, 1, 0, 10'h0, 0, 10'h0);
         checkOutput("cw_wait_n",  16'(wait_n),  16'h0);
         checkOutput("cw_cram_we", 16'(cram_we), 16'h0);
      end
      applyStimulus(0, 0, 1, 0, 16'h2C10, 8'h3C, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("cw_grant_we",    16'(cram_we),    16'h1);
      checkOutput("cw_grant_addr",  16'(cram_addr),  16'h010);
      checkOutput("cw_grant_wdata", 16'(cram_wdata), 16'h003C);
      checkOutput("cw_grant_wait",  16'(wait_n),     16'h1);
      applyStimulus(0, 0, 1, 0, 16'h2C10, 8'h3C, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("cw_done_we",   16'(cram_we), 16'h0);
      checkOutput("cw_done_wait", 16'(wait_n),  16'h1);
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("cw_write_count", 16'(c_writes - c_base), 16'h1);
      checkOutput("cw_mem",         16'(cmem[10'h010]),     16'h003C);

      $display("[TB] no-wait collision");
      applyStimulus(0, 0, 0, 1, 16'h2003, 8'h00, 1, 0, 10'h0, 0, 10'h0);
      checkOutput("col_wait_n_n", 16'(wait_n), 16'h1);
      applyStimulus(0, 0, 0, 1, 16'h2003, 8'h00, 1, 1, 10'h009, 0, 10'h0);
      scr_q.push_back(8'hFF);
      cpu_q.push_back(smem[3]);
      checkOutput("col_wait_n_g", 16'(wait_n),    16'h1);
      checkOutput("col_sram_addr", 16'(sram_addr), 16'h003);
      applyStimulus(0, 0, 0, 1, 16'h2003, 8'h00, 1, 0, 10'h0, 0, 10'h0);
      checkOutput("col_scr_valid", 16'(vid_scr_valid), 16'h1);
      checkOutput("col_scr_data",  16'(vid_scr_data),  16'(scr_q.pop_front()));
      checkOutput("col_din_oe",    16'(cpu_din_oe),    16'h1);
      checkOutput("col_cpu_din",   16'(cpu_din),       16'(cpu_q.pop_front()));
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);

      $display("[TB] independence");
      applyStimulus(0, 0, 0, 1, 16'h2400, 8'h00, 1, 0, 10'h009, 0, 10'h0);
      checkOutput("ind_wait_n_n", 16'(wait_n), 16'h0);
      applyStimulus(0, 0, 0, 1, 16'h2400, 8'h00, 1, 0, 10'h009, 1, 10'h1F0);
      chr_q.push_back(cmem[10'h1F0]);
      checkOutput("ind_wait_n_req", 16'(wait_n),    16'h0);
      checkOutput("ind_cram_addr",  16'(cram_addr), 16'h01F0);
      applyStimulus(0, 0, 0, 1, 16'h2400, 8'h00, 1, 0, 10'h009, 0, 10'h0);
      checkOutput("ind_chr_valid", 16'(vid_chr_valid), 16'h1);
      checkOutput("ind_chr_data",  16'(vid_chr_data),  16'(chr_q.pop_front()));
      checkOutput("ind_wait_n_d",  16'(wait_n),        16'h0);
      applyStimulus(0, 0, 0, 1, 16'h2400, 8'h00, 0, 0, 10'h009, 0, 10'h0);
      cpu_q.push_back(smem[0]);
      checkOutput("ind_grant_wait", 16'(wait_n),    16'h1);
      checkOutput("ind_grant_addr", 16'(sram_addr), 16'h000);
      applyStimulus(0, 0, 0, 1, 16'h2400, 8'h00, 0, 0, 10'h009, 0, 10'h0);
      checkOutput("ind_din_oe",  16'(cpu_din_oe), 16'h1);
      checkOutput("ind_cpu_din", 16'(cpu_din),    16'(cpu_q.pop_front()));
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);

      $display("[TB] reset during pending write");
      s_base = s_writes;
      applyStimulus(0, 0, 1, 0, 16'h2410, 8'h99, 1, 0, 10'h0, 0, 10'h0);
      checkOutput("rp_wait_n_n", 16'(wait_n), 16'h0);
      applyStimulus(0, 0, 1, 0, 16'h2410, 8'h99, 1, 0, 10'h0, 0, 10'h0);
      checkOutput("rp_wait_n_p", 16'(wait_n),  16'h0);
      checkOutput("rp_sram_we_p", 16'(sram_we), 16'h0);
      applyStimulus(1, 0, 1, 0, 16'h2410, 8'h99, 1, 0, 10'h0, 0, 10'h0);
      checkOutput("rp_rst_we",     16'(sram_we), 16'h0);
      checkOutput("rp_rst_wait_n", 16'(wait_n),  16'h1);
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("rp_after_wait_n",    16'(wait_n),        16'h1);
      checkOutput("rp_after_scr_valid", 16'(vid_scr_valid), 16'h0);
      checkOutput("rp_after_chr_valid", 16'(vid_chr_valid), 16'h0);
      checkOutput("rp_after_sram_we",   16'(sram_we),       16'h0);
      checkOutput("rp_after_din_oe",    16'(cpu_din_oe),    16'h0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);
         checkOutput("rp_idle_sram_we", 16'(sram_we), 16'h0);
      end
      checkOutput("rp_write_count", 16'(s_writes - s_base), 16'h0);
      checkOutput("rp_mem",         16'(smem[10'h010]),     16'h00EE);

      $display("[TB] fresh read after reset");
      applyStimulus(0, 0, 0, 1, 16'h2405, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("fr_wait_n", 16'(wait_n), 16'h1);
      applyStimulus(0, 0, 0, 1, 16'h2405, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      cpu_q.push_back(smem[5]);
      checkOutput("fr_sram_addr", 16'(sram_addr), 16'h005);
      applyStimulus(0, 0, 0, 1, 16'h2405, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("fr_din_oe",  16'(cpu_din_oe), 16'h1);
      checkOutput("fr_cpu_din", 16'(cpu_din),    16'(cpu_q.pop_front()));
      applyStimulus(0, 1, 1, 1, 16'h0000, 8'h00, 0, 0, 10'h0, 0, 10'h0);
      checkOutput("fr_total_writes", 16'(s_writes - s_base), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
